// File: rtl/coin_detector.sv
// Coin sensor front-end: synchronises and debounces three raw coin lines and issues
// queued coins as one-hot single-cycle pulses, 25 kurus first, while the FSM is not holding.
module coin_detector #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int PEND_W          = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic coin5_raw,
  input  logic coin10_raw,
  input  logic coin25_raw,
  input  logic hold,
  output logic A_in,
  output logic B_in,
  output logic C_in,
  output logic pending,
  output logic ovf
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [PEND_W-1:0] PEND_MAX = '1;

  // Channel index 0 = 5 kurus (A), 1 = 10 kurus (B), 2 = 25 kurus (C).
  logic [2:0] rawLines;
  logic [2:0] sync1_q, sync2_q;
  logic [2:0] level_q, level_d;
  logic [2:0] coinEvent;
  logic [2:0][CNT_W-1:0] bounce_q, bounce_d;
  logic [2:0][PEND_W-1:0] pend_q, pend_d;
  logic [2:0] issue_q, issue_d;
  logic [2:0] drop;
  logic ovf_q, ovf_d;

  assign rawLines = {coin25_raw, coin10_raw, coin5_raw};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q  <= '0;
      sync2_q  <= '0;
      level_q  <= '0;
      bounce_q <= '0;
      pend_q   <= '0;
      issue_q  <= '0;
      ovf_q    <= 1'b0;
    end else begin
      sync1_q  <= rawLines;
      sync2_q  <= sync1_q;
      level_q  <= level_d;
      bounce_q <= bounce_d;
      pend_q   <= pend_d;
      issue_q  <= issue_d;
      ovf_q    <= ovf_d;
    end
  end

  // The level flips on the DEBOUNCE_CYCLES-th consecutive disagreeing sample; only rises are coins.
  always_comb begin
    level_d   = level_q;
    bounce_d  = '0;
    coinEvent = '0;
    for (int i = 0; i < 3; i++) begin
      if (sync2_q[i] != level_q[i]) begin
        if (bounce_q[i] == DEB_LAST) begin
          level_d[i]   = sync2_q[i];
          coinEvent[i] = sync2_q[i];
        end else begin
          bounce_d[i] = bounce_q[i] + 1'b1;
        end
      end
    end
  end

  always_comb begin
    issue_d = '0;
    if (!hold) begin
      if (pend_q[2] != '0)      issue_d = 3'b100;
      else if (pend_q[1] != '0) issue_d = 3'b010;
      else if (pend_q[0] != '0) issue_d = 3'b001;
    end
  end

  // A same-cycle issue frees the slot, so only an event landing on a full, undrained counter is lost.
  always_comb begin
    pend_d = pend_q;
    drop   = '0;
    for (int i = 0; i < 3; i++) begin
      if (issue_d[i] && !coinEvent[i]) begin
        pend_d[i] = pend_q[i] - 1'b1;
      end else if (coinEvent[i] && !issue_d[i]) begin
        if (pend_q[i] != PEND_MAX) pend_d[i] = pend_q[i] + 1'b1;
        else                       drop[i]   = 1'b1;
      end
    end
    ovf_d = ovf_q | (|drop);
  end

  assign A_in    = issue_q[0];
  assign B_in    = issue_q[1];
  assign C_in    = issue_q[2];
  assign ovf     = ovf_q;
  assign pending = (pend_q[0] != '0) | (pend_q[1] != '0) | (pend_q[2] != '0);

endmodule

// File: tb/tb_coin_detector.sv
// Bench for coin_detector: directed coin scenarios plus random bouncy lines and hold,
// all compared every cycle against a sample-history reference model.
module tb_coin_detector;

  localparam int DEB  = 4;
  localparam int PMAX = 3;

  logic clk = 1'b0;
  logic rst, coin5_raw, coin10_raw, coin25_raw, hold;
  logic A_in, B_in, C_in, pending, ovf;

  int checks = 0;
  int errors = 0;

  logic [2:0] rawLog[$];
  bit   [2:0] mLevel;
  int         mRun[3];
  int         mPend[3];
  bit         mOvf;
  bit   [2:0] expPulse;

  int cntA, cntB, cntC, kurus;
  int pulseOrder[$];

  coin_detector #(.DEBOUNCE_CYCLES(DEB), .PEND_W(2)) dut (
    .clk(clk), .rst(rst),
    .coin5_raw(coin5_raw), .coin10_raw(coin10_raw), .coin25_raw(coin25_raw),
    .hold(hold),
    .A_in(A_in), .B_in(B_in), .C_in(C_in),
    .pending(pending), .ovf(ovf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Reference: each edge sees the raw value from two edges earlier; a run of DEB
  // disagreeing samples moves the level; queued coins drain highest value first.
  task automatic modelStep();
    logic [2:0] seen;
    logic [2:0] ev;
    rawLog.push_back({coin25_raw, coin10_raw, coin5_raw});
    if (rawLog.size() > 3) void'(rawLog.pop_front());
    seen = (rawLog.size() == 3) ? rawLog[0] : 3'b000;
    ev = '0;
    for (int i = 0; i < 3; i++) begin
      if (seen[i] != mLevel[i]) begin
        mRun[i]++;
        if (mRun[i] == DEB) begin
          mLevel[i] = seen[i];
          mRun[i] = 0;
          ev[i] = seen[i];
        end
      end else begin
        mRun[i] = 0;
      end
    end
    expPulse = '0;
    if (!hold) begin
      for (int i = 2; i >= 0; i--) begin
        if (mPend[i] > 0 && expPulse == 3'b000) begin
          expPulse[i] = 1'b1;
          mPend[i]--;
        end
      end
    end
    for (int i = 0; i < 3; i++) begin
      if (ev[i]) begin
        if (mPend[i] < PMAX) mPend[i]++;
        else mOvf = 1'b1;
      end
    end
  endtask

  task automatic checkOutput();
    chk("A_in", A_in, expPulse[0]);
    chk("B_in", B_in, expPulse[1]);
    chk("C_in", C_in, expPulse[2]);
    chk("pending", pending, (mPend[0] > 0 || mPend[1] > 0 || mPend[2] > 0));
    chk("ovf", ovf, mOvf);
    chk("onehot", ($countones({C_in, B_in, A_in}) <= 1), 1);
  endtask

  task automatic tick();
    @(posedge clk);
    modelStep();
    @(negedge clk);
    checkOutput();
    if (A_in) begin cntA++; kurus += 5;  pulseOrder.push_back(0); end
    if (B_in) begin cntB++; kurus += 10; pulseOrder.push_back(1); end
    if (C_in) begin cntC++; kurus += 25; pulseOrder.push_back(2); end
  endtask

  task automatic applyStimulus(input int cycles, input logic [2:0] lines);
    {coin25_raw, coin10_raw, coin5_raw} = lines;
    repeat (cycles) tick();
  endtask

  task automatic doReset();
    rst = 1'b1;
    coin5_raw = 1'b0; coin10_raw = 1'b0; coin25_raw = 1'b0; hold = 1'b0;
    rawLog.delete();
    mLevel = '0; mOvf = 1'b0; expPulse = '0;
    for (int i = 0; i < 3; i++) begin mRun[i] = 0; mPend[i] = 0; end
    cntA = 0; cntB = 0; cntC = 0; kurus = 0;
    pulseOrder.delete();
    #1;
    chk("rst_outs", {A_in, B_in, C_in, pending, ovf}, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    int firstIdx[3];
    int lastC;
    logic sawPending;
    logic [13:0] bounce;

    // Single 5-kurus coin held 10 cycles.
    doReset();
    coin5_raw = 1'b1;
    firstIdx[0] = -1;
    for (int t = 0; t < 20; t++) begin
      if (t == 10) coin5_raw = 1'b0;
      tick();
      if (A_in && firstIdx[0] < 0) firstIdx[0] = t;
    end
    chk("t1_a_edge", firstIdx[0], 6);
    chk("t1_a_count", cntA, 1);
    chk("t1_bc_count", cntB + cntC, 0);

    // Short pulse and bounce on the 10-kurus line must be ignored.
    doReset();
    bounce = 14'b01101000000111;
    sawPending = 1'b0;
    for (int t = 0; t < 24; t++) begin
      coin10_raw = (t < 14) ? bounce[t] : 1'b0;
      tick();
      sawPending |= pending;
    end
    chk("t2_b_count", cntB, 0);
    chk("t2_ovf", ovf, 0);
    chk("t2_pending", sawPending, 0);

    // Three coins together drain C, B, A on consecutive cycles.
    doReset();
    for (int i = 0; i < 3; i++) firstIdx[i] = -1;
    {coin25_raw, coin10_raw, coin5_raw} = 3'b111;
    for (int t = 0; t < 12; t++) begin
      if (t == 8) {coin25_raw, coin10_raw, coin5_raw} = 3'b000;
      tick();
      if (A_in && firstIdx[0] < 0) firstIdx[0] = t;
      if (B_in && firstIdx[1] < 0) firstIdx[1] = t;
      if (C_in && firstIdx[2] < 0) firstIdx[2] = t;
    end
    chk("t3_c_edge", firstIdx[2], 6);
    chk("t3_b_edge", firstIdx[1], 7);
    chk("t3_a_edge", firstIdx[0], 8);
    chk("t3_pending_end", pending, 0);

    // Five 25-kurus coins under hold: three queue, two overflow.
    doReset();
    hold = 1'b1;
    repeat (5) begin
      applyStimulus(8, 3'b100);
      applyStimulus(8, 3'b000);
    end
    chk("t4_c_held", cntC, 0);
    chk("t4_pending", pending, 1);
    chk("t4_ovf", ovf, 1);
    hold = 1'b0;
    firstIdx[2] = -1; lastC = -1;
    for (int t = 0; t < 8; t++) begin
      tick();
      if (C_in) begin
        if (firstIdx[2] < 0) firstIdx[2] = t;
        lastC = t;
      end
    end
    chk("t4_c_count", cntC, 3);
    chk("t4_c_span", lastC - firstIdx[2], 2);
    chk("t4_ovf_sticky", ovf, 1);

    // Reset in the middle of a cycle with two B coins queued.
    doReset();
    hold = 1'b1;
    repeat (2) begin
      applyStimulus(8, 3'b010);
      applyStimulus(8, 3'b000);
    end
    chk("t5_pending_pre", pending, 1);
    #2;
    doReset();
    chk("t5_pending_post", pending, 0);
    applyStimulus(20, 3'b000);
    chk("t5_b_count", cntB, 0);
    chk("t5_ovf", ovf, 0);

    // 5, 10, 25, 25 spaced 20 cycles apart.
    doReset();
    applyStimulus(6, 3'b001); applyStimulus(14, 3'b000);
    applyStimulus(6, 3'b010); applyStimulus(14, 3'b000);
    applyStimulus(6, 3'b100); applyStimulus(14, 3'b000);
    applyStimulus(6, 3'b100); applyStimulus(14, 3'b000);
    chk("t6_pulses", pulseOrder.size(), 4);
    if (pulseOrder.size() == 4) begin
      chk("t6_order0", pulseOrder[0], 0);
      chk("t6_order1", pulseOrder[1], 1);
      chk("t6_order2", pulseOrder[2], 2);
      chk("t6_order3", pulseOrder[3], 2);
    end
    chk("t6_kurus", kurus, 65);

    // Random bouncy lines with random hold, checked cycle by cycle.
    doReset();
    for (int t = 0; t < 600; t++) begin
      if ($urandom_range(0, 5) == 0) coin5_raw  = ~coin5_raw;
      if ($urandom_range(0, 5) == 0) coin10_raw = ~coin10_raw;
      if ($urandom_range(0, 5) == 0) coin25_raw = ~coin25_raw;
      if ($urandom_range(0, 9) == 0) hold = ~hold;
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
